// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target that exposes an 8-bit-addressed register space
// to an external host on the shared bus.
//
// Ports:
//   clk25       25 MHz system clock; SCL/SDA are oversampled in this domain
//   reset_n     asynchronous, active-low reset
//   scl_i       raw SCL pad level
//   sda_i       raw SDA pad level (wired-AND of host and our sda_oe)
//   sda_oe      1 = pull SDA low, 0 = release
//   reg_addr    current register pointer (wraps 0xFF -> 0x00)
//   wr_data     write byte, valid while wr_strobe = 1
//   wr_strobe   one-cycle pulse: write wr_data to reg_addr
//   rd_data     read data for reg_addr, combinational from reg_addr
//   rd_strobe   one-cycle pulse: rd_data is being captured for transmit
//   busy        1 from accepted START until STOP or reset
//   fsm_state_o debug view of the protocol state
//
// Register interface handshake: there is no back-pressure. wr_strobe and
// rd_strobe are single-cycle pulses the surrounding logic must accept on the
// cycle they appear; rd_data must be valid one cycle after reg_addr changes.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h3C,
  parameter int         FILTER_LEN = 3,
  parameter int         HOLD_CYC   = 8
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  input  logic [7:0] rd_data,
  output logic       rd_strobe,
  output logic       busy,
  output logic [2:0] fsm_state_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_t;

  // Bit 0 carries SCL, bit 1 carries SDA through the input path.
  logic [1:0]    raw, sync1_q, sync2_q, filt_q, filt_p_q;
  logic [CW-1:0] fcnt_q [2];

  assign raw = {sda_i, scl_i};

  // Synchronizer + glitch filter: the filtered level flips only after
  // FILTER_LEN consecutive synchronized samples disagree with it.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      filt_p_q  <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      filt_p_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, sda_f, start_det, stop_det;
  assign scl_rise  = filt_q[0] & ~filt_p_q[0];
  assign scl_fall  = ~filt_q[0] & filt_p_q[0];
  assign sda_f     = filt_q[1];
  // Uses the already-updated SCL level, so an SCL edge in the same cycle is
  // effectively handled before the START/STOP decision.
  assign start_det = ~filt_q[1] & filt_p_q[1] & filt_q[0];
  assign stop_det  = filt_q[1] & ~filt_p_q[1] & filt_q[0];

  state_t        state_q, state_d;
  logic [3:0]    bit_q, bit_d;        // bits completed in the current byte; 8 = ack clock
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    reg_addr_q, addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic          rd_strobe_q, rd_strobe_d;
  logic          sda_oe_q, oe_d;
  logic [HW-1:0] hold_q, hold_d;      // countdown to the next sda_oe update
  logic [7:0]    rx_byte;
  logic          oe_want;

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    addr_d      = reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    oe_d        = sda_oe_q;
    hold_d      = hold_q;
    rx_byte     = {shift_q[6:0], sda_f};

    // Level SDA should take for the current low phase of SCL.
    case (state_q)
      ST_ADDR, ST_PTR, ST_WDATA: oe_want = (bit_q == 4'd8);
      ST_RDATA:                  oe_want = (bit_q != 4'd8) && !shift_q[7];
      default:                   oe_want = 1'b0;
    endcase

    if (wr_strobe_q) addr_d  = reg_addr_q + 8'd1;
    if (rd_strobe_q) shift_d = rd_data;

    if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
      if (hold_q == HW'(1)) oe_d = oe_want;
    end

    if (scl_fall) begin
      hold_d = HW'(HOLD_CYC);
      // bit_q == 0 in RDATA only on the fall that ends an ACK bit.
      if (state_q == ST_RDATA && bit_q == 4'd0) rd_strobe_d = 1'b1;
    end

    if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (bit_q != 4'd8) begin
            shift_d = rx_byte;
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              if (state_q == ST_ADDR && rx_byte[7:1] != DEV_ADDR) state_d = ST_IGNORE;
              if (state_q == ST_PTR) addr_d = rx_byte;
            end
          end else begin
            bit_d = 4'd0;
            if (state_q == ST_ADDR) begin
              state_d = shift_q[0] ? ST_RDATA : ST_PTR;
            end else if (state_q == ST_PTR) begin
              state_d = ST_WDATA;
            end else begin
              wr_data_d   = shift_q;
              wr_strobe_d = 1'b1;
            end
          end
        end
        ST_RDATA: begin
          if (bit_q != 4'd8) begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 4'd1;
          end else begin
            bit_d = 4'd0;
            if (!sda_f) addr_d  = reg_addr_q + 8'd1;
            else        state_d = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end

    if (start_det || stop_det) begin
      state_d = start_det ? ST_ADDR : ST_IDLE;
      bit_d   = 4'd0;
      oe_d    = 1'b0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_q       <= 4'd0;
      shift_q     <= 8'h00;
      reg_addr_q  <= 8'h00;
      wr_data_q   <= 8'h00;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      reg_addr_q  <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      sda_oe_q    <= oe_d;
      hold_q      <= hold_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign reg_addr    = reg_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_strobe   = wr_strobe_q;
  assign rd_strobe   = rd_strobe_q;
  assign busy        = (state_q != ST_IDLE);
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
module tb_i2c_target_regs;

  localparam int Q = 40;  // clk25 cycles per quarter SCL period

  // Clock / reset
  logic clk25 = 1'b0;
  logic reset_n = 1'b0;
  always #20 clk25 = ~clk25;

  logic       host_scl = 1'b1;
  logic       host_sda = 1'b1;
  logic       sda_oe, wr_strobe, rd_strobe, busy;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic [2:0] fsm_state;
  wire        sda_line = host_sda & ~sda_oe;

  i2c_target_regs dut (
    .clk25(clk25), .reset_n(reset_n), .scl_i(host_scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .rd_data(rd_data), .rd_strobe(rd_strobe), .busy(busy), .fsm_state_o(fsm_state)
  );

  // Register file environment seen by the DUT
  logic [7:0] mem [256];
  assign rd_data = mem[reg_addr];

  // Reference model: register contents and host-visible pointer
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;
  logic [15:0] exp_q [$];   // expected {addr, data} per write strobe
  logic [7:0]  tx_q [$];    // payload bytes for the next write transaction

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic oe_seen = 1'b0;
  logic prev_wr = 1'b0;

  // Scoreboard monitor
  always @(negedge clk25) begin
    if (sda_oe) oe_seen = 1'b1;
    if (rd_strobe) rd_cnt++;
    if (wr_strobe) begin
      logic [15:0] e;
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", reg_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({reg_addr, wr_data} !== e) begin
          failures++;
          $display("FAIL wr_strobe: got addr=%h data=%h, required addr=%h data=%h",
                   reg_addr, wr_data, e[15:8], e[7:0]);
        end
      end
      checks++;
      if (prev_wr) begin
        failures++;
        $display("FAIL wr_pulse_width: got 2+ cycles, required 1");
      end
      mem[reg_addr] = wr_data;
    end
    prev_wr = wr_strobe;
  end

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks (all drives happen on the falling clock edge)
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic bus_start();
    host_sda = 1'b1; wait_cyc(Q);
    host_scl = 1'b1; wait_cyc(Q);
    host_sda = 1'b0; wait_cyc(Q);
    host_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_stop();
    host_sda = 1'b0; wait_cyc(Q);
    host_scl = 1'b1; wait_cyc(Q);
    host_sda = 1'b1; wait_cyc(2 * Q);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    host_sda = b;    wait_cyc(Q);
    host_scl = 1'b1; wait_cyc(Q);
    r = sda_line;    wait_cyc(Q);
    host_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack_n);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack_n);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  // Full write transaction: START, 0x78, ptr, tx_q bytes, STOP
  task automatic do_write(input logic [7:0] ptr);
    logic a;
    logic [7:0] p;
    p = ptr;
    bus_start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start: got %b, required 1", busy); end
    send_byte(8'h78, a);
    checks++;
    if (a !== 1'b0) begin failures++; $display("FAIL ack_addr_w: got %b, required 0", a); end
    send_byte(ptr, a);
    checks++;
    if (a !== 1'b0) begin failures++; $display("FAIL ack_ptr: got %b, required 0", a); end
    while (tx_q.size() > 0) begin
      logic [7:0] d;
      d = tx_q.pop_front();
      exp_q.push_back({p, d});
      model_mem[p] = d;
      p = p + 8'd1;
      send_byte(d, a);
      checks++;
      if (a !== 1'b0) begin failures++; $display("FAIL ack_data: got %b, required 0", a); end
    end
    model_ptr = p;
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_stop: got %b, required 0", busy); end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL wr_missing: got %0d pending, required 0", exp_q.size());
    end
    checks++;
    if (reg_addr !== model_ptr) begin
      failures++; $display("FAIL ptr_after_write: got %h, required %h", reg_addr, model_ptr);
    end
  endtask

  // Full read transaction: START, 0x78, ptr, rSTART, 0x79, n bytes, STOP
  task automatic do_read(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] d;
    int rd0;
    rd0 = rd_cnt;
    model_ptr = ptr;
    bus_start();
    send_byte(8'h78, a);
    send_byte(ptr, a);
    bus_start();
    send_byte(8'h79, a);
    checks++;
    if (a !== 1'b0) begin failures++; $display("FAIL ack_addr_r: got %b, required 0", a); end
    for (int k = 0; k < n; k++) begin
      recv_byte((k == n - 1), d);
      checks++;
      if (d !== model_mem[model_ptr]) begin
        failures++;
        $display("FAIL rd_byte: got %h, required %h at %h", d, model_mem[model_ptr], model_ptr);
      end
      if (k != n - 1) model_ptr = model_ptr + 8'd1;
    end
    bus_stop();
    checks++;
    if (rd_cnt - rd0 != n) begin
      failures++; $display("FAIL rd_strobe_count: got %0d, required %0d", rd_cnt - rd0, n);
    end
    checks++;
    if (reg_addr !== model_ptr) begin
      failures++; $display("FAIL ptr_after_read: got %h, required %h", reg_addr, model_ptr);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({sda_oe, reg_addr, wr_data, wr_strobe, rd_strobe, busy} !== 20'h0) begin
      failures++;
      $display("FAIL reset_%s: got oe=%b addr=%h wd=%h ws=%b rs=%b busy=%b, required all zero",
               tag, sda_oe, reg_addr, wr_data, wr_strobe, rd_strobe, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cyc(5);
    check_reset_values("initial");
    reset_n = 1'b1;
    wait_cyc(20);
    check_reset_values("released");
  endtask

  task automatic test_write();
    tx_q = '{8'hA5, 8'h5A};
    do_write(8'h10);
  endtask

  task automatic test_read();
    do_read(8'h20, 2);
  endtask

  task automatic test_mismatch();
    logic a;
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    oe_seen = 1'b0;
    bus_start();
    send_byte(8'h7A, a);
    checks++;
    if (a !== 1'b1) begin failures++; $display("FAIL nack_addr: got %b, required 1", a); end
    send_byte(8'h00, a);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_ignore: got %b, required 1", busy); end
    bus_stop();
    checks++;
    if (oe_seen !== 1'b0) begin failures++; $display("FAIL oe_on_mismatch: got 1, required 0"); end
    checks++;
    if (wr_cnt != w0 || rd_cnt != r0) begin
      failures++; $display("FAIL strobes_on_mismatch: got %0d/%0d, required 0/0", wr_cnt - w0, rd_cnt - r0);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_stop_ignore: got %b, required 0", busy); end
  endtask

  task automatic test_glitch();
    logic seen;
    for (int len = 2; len <= 3; len++) begin
      seen = 1'b0;
      wait_cyc(10);
      host_sda = 1'b0;
      wait_cyc(len);
      host_sda = 1'b1;
      for (int c = 0; c < 30; c++) begin
        wait_cyc(1);
        if (busy) seen = 1'b1;
      end
      checks++;
      if (seen !== (len == 3)) begin
        failures++; $display("FAIL glitch_len%0d: got busy_seen=%b, required %b", len, seen, (len == 3));
      end
    end
  endtask

  task automatic test_wrap();
    tx_q = '{8'h11, 8'h22};
    do_write(8'hFF);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      logic [7:0] p;
      int n;
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      do_write(p);
      do_read(p, n);
    end
  endtask

  task automatic test_back_to_back();
    // Two writes with no idle gap beyond the STOP, then a read spanning both.
    tx_q = '{8'($urandom), 8'($urandom)};
    do_write(8'h60);
    tx_q = '{8'($urandom)};
    do_write(8'h62);
    do_read(8'h60, 3);
  endtask

  task automatic test_reset_mid();
    logic a;
    tx_q = '{8'h00};
    do_write(8'h80);
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'h80, a);
    bus_start();
    send_byte(8'h79, a);
    // First data bit of 0x00 is being driven low now.
    checks++;
    if (sda_oe !== 1'b1) begin failures++; $display("FAIL oe_drive_zero: got %b, required 1", sda_oe); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL oe_async_reset: got %b, required 0", sda_oe); end
    check_reset_values("mid");
    host_scl = 1'b1;
    host_sda = 1'b1;
    wait_cyc(10);
    reset_n = 1'b1;
    wait_cyc(20);
    check_reset_values("after_mid");
    tx_q = '{8'hA5, 8'h5A};
    do_write(8'h10);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = ~8'(i);
      model_mem[i] = ~8'(i);
    end
    model_ptr = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_glitch();
    test_wrap();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
